pdm_mic_ctrl: RTL and testbench

//  Sequencer and sample scheduler for the PDM microphone front-end. Gates the mic clock,

---
 rtl/pdm_mic_ctrl_pkg.sv | 17 +
 rtl/pdm_mic_ctrl_sample_fifo.sv | 69 ++++++
 rtl/pdm_mic_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pdm_mic_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_mic_ctrl_pkg.sv
// Shared definitions for the PDM microphone controller: FSM state encodings
// and a counter-width helper.
package pdm_mic_ctrl_pkg;

    localparam int ST_W = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_FILL   = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pdm_mic_ctrl_sample_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; reports pushes that
// were dropped because the FIFO was full and nothing left that cycle.
module sample_fifo
    import pdm_mic_ctrl_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic         drop_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          full_s;
    logic          empty_s;
    logic          do_push_s;
    logic          do_pop_s;

    assign full_s    = (count_q == CW'(DEPTH));
    assign empty_s   = (count_q == '0);
    assign do_pop_s  = pop_i & ~empty_s;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push_s = push_i & (~full_s | do_pop_s);
    assign drop_o    = push_i & full_s & ~do_pop_s;
    assign dout_o    = mem_q[rd_ptr_q];
    assign valid_o   = ~empty_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pdm_mic_ctrl.sv
// PDM mic sequencer and sample decimator feeding a small output FIFO.
// Optional peak-hold tracker enabled by defining PDM_MIC_PEAK_HOLD_EN.
module pdm_mic_ctrl
    import pdm_mic_ctrl_pkg::*;
#(
    parameter int SAMPLE_DEPTH = 16,
    parameter int DECIM        = 50,
    parameter int WARMUP_TICKS = 4096,
    parameter int FILL_TICKS   = 512,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic                    bit_tick_i,
    input  logic [SAMPLE_DEPTH-1:0] audio_in_i,
    output logic                    mic_run_o,
    output logic [SAMPLE_DEPTH-1:0] sample_data_o,
    output logic                    sample_valid_o,
    input  logic                    sample_ready_i,
    output logic                    overflow_o,
    input  logic                    clear_ovf_i,
`ifdef PDM_MIC_PEAK_HOLD_EN
    input  logic                    peak_clr_i,
    output logic [SAMPLE_DEPTH-2:0] peak_level_o,
`endif
    output logic [ST_W-1:0]         state_o
);

    localparam int MAX_A  = (WARMUP_TICKS > FILL_TICKS) ? WARMUP_TICKS : FILL_TICKS;
    localparam int CNT_MX = (MAX_A > DECIM) ? MAX_A : DECIM;
    localparam int CW     = cnt_w(CNT_MX);

    localparam logic [CW-1:0] WARM_LAST  = CW'(WARMUP_TICKS - 1);
    localparam logic [CW-1:0] FILL_LAST  = CW'(FILL_TICKS - 1);
    localparam logic [CW-1:0] DECIM_LAST = CW'(DECIM - 1);

    logic [ST_W-1:0] state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mic_run_q;
    logic            ovf_q, ovf_d;
    logic            push_s;
    logic            drop_s;

    // Sequencer: one shared tick counter serves warm-up, fill and decimation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        push_s  = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WARMUP;
                    cnt_d   = '0;
                end
                ST_WARMUP: begin
                    if (bit_tick_i) begin
                        if (cnt_q == WARM_LAST) begin
                            state_d = ST_FILL;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_FILL: begin
                    if (bit_tick_i) begin
                        if (cnt_q == FILL_LAST) begin
                            state_d = ST_RUN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_RUN: begin
                    if (bit_tick_i) begin
                        if (cnt_q == DECIM_LAST) begin
                            push_s = 1'b1;
                            cnt_d  = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Overflow is sticky across disable; a new drop beats a same-cycle clear.
    always_comb begin
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clear_ovf_i) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State, counter, mic clock gate and overflow registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mic_run_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mic_run_q <= (state_d != ST_IDLE);
            ovf_q     <= ovf_d;
        end
    end

    sample_fifo #(
        .W     (SAMPLE_DEPTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (~enable_i),
        .push_i  (push_s),
        .din_i   (audio_in_i),
        .pop_i   (sample_ready_i),
        .dout_o  (sample_data_o),
        .valid_o (sample_valid_o),
        .drop_o  (drop_s)
    );

    assign mic_run_o  = mic_run_q;
    assign overflow_o = ovf_q;
    assign state_o    = state_q;

`ifdef PDM_MIC_PEAK_HOLD_EN
    logic [SAMPLE_DEPTH-2:0] peak_q, peak_d;
    logic [SAMPLE_DEPTH-2:0] mag_s;

    // Magnitude of a signed sample; the most-negative value saturates.
    function automatic logic [SAMPLE_DEPTH-2:0] abs_mag(input logic [SAMPLE_DEPTH-1:0] v);
        logic [SAMPLE_DEPTH-1:0] m;
        m = v[SAMPLE_DEPTH-1] ? (~v + SAMPLE_DEPTH'(1)) : v;
        return m[SAMPLE_DEPTH-1] ? '1 : m[SAMPLE_DEPTH-2:0];
    endfunction

    assign mag_s = abs_mag(audio_in_i);

    // Peak tracks every decimated sample, including dropped ones.
    always_comb begin
        if (push_s) begin
            peak_d = (mag_s > peak_q) ? mag_s : peak_q;
        end else if (peak_clr_i) begin
            peak_d = '0;
        end else begin
            peak_d = peak_q;
        end
    end

    // Peak register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_level_o = peak_q;
`endif

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// Directed self-checking bench for pdm_mic_ctrl (small warm-up/fill/decimation
// counts, bit_tick every third clock).
module tb_pdm_mic_ctrl;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        bit_tick;
    logic [15:0] audio_in;
    logic        mic_run;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        overflow;
    logic        clear_ovf;
    logic [1:0]  state;
`ifdef PDM_MIC_PEAK_HOLD_EN
    logic        peak_clr;
    logic [14:0] peak_level;
`endif

    int   errors;
    int   checks;
    logic ramp;
    logic [15:0] exp_q [4];
    logic [15:0] v4;

    pdm_mic_ctrl #(
        .SAMPLE_DEPTH (16),
        .DECIM        (4),
        .WARMUP_TICKS (8),
        .FILL_TICKS   (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable),
        .bit_tick_i     (bit_tick),
        .audio_in_i     (audio_in),
        .mic_run_o      (mic_run),
        .sample_data_o  (sample_data),
        .sample_valid_o (sample_valid),
        .sample_ready_i (sample_ready),
        .overflow_o     (overflow),
        .clear_ovf_i    (clear_ovf),
`ifdef PDM_MIC_PEAK_HOLD_EN
        .peak_clr_i     (peak_clr),
        .peak_level_o   (peak_level),
`endif
        .state_o        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (ramp) audio_in = audio_in + 16'd1;
    endtask

    // One clock with bit_tick asserted at the edge.
    task automatic do_tick();
        bit_tick = 1'b1;
        step();
        bit_tick = 1'b0;
    endtask

    task automatic idle2();
        step();
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do_tick();
            idle2();
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        ramp         = 1'b0;
        rst          = 1'b1;
        enable       = 1'b0;
        bit_tick     = 1'b0;
        audio_in     = 16'd1000;
        sample_ready = 1'b0;
        clear_ovf    = 1'b0;
`ifdef PDM_MIC_PEAK_HOLD_EN
        peak_clr     = 1'b0;
`endif
        step();
        step();
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_mic_run", {31'd0, mic_run}, 32'd0);
        check("rst_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_data", {16'd0, sample_data}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        step();
        check("idle_hold", {30'd0, state}, 32'd0);

        // 1: sequencing through warm-up and fill
        enable = 1'b1;
        step();
        check("warmup_entry", {30'd0, state}, 32'd1);
        check("mic_run_on", {31'd0, mic_run}, 32'd1);
        ticks(7);
        check("warmup_7", {30'd0, state}, 32'd1);
        ticks(1);
        check("fill_entry", {30'd0, state}, 32'd2);
        ticks(3);
        check("fill_3", {30'd0, state}, 32'd2);
        ticks(1);
        check("run_entry", {30'd0, state}, 32'd3);
        check("run_no_sample", {31'd0, sample_valid}, 32'd0);

        // 2: decimation with ramping audio and an always-ready consumer
        ramp         = 1'b1;
        sample_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            ticks(3);
            check("dec_not_yet", {31'd0, sample_valid}, 32'd0);
            v4 = audio_in;
            do_tick();
            check("dec_valid", {31'd0, sample_valid}, 32'd1);
            check("dec_data", {16'd0, sample_data}, {16'd0, v4});
            idle2();
            check("dec_popped", {31'd0, sample_valid}, 32'd0);
        end

        // 3: consumer stalls; four samples held, fifth dropped
        sample_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ticks(3);
            exp_q[k] = audio_in;
            ticks(1);
        end
        check("full_no_ovf", {31'd0, overflow}, 32'd0);
        ticks(4);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("full_head", {16'd0, sample_data}, {16'd0, exp_q[0]});
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // 4: push and pop in the same cycle on a full FIFO
        ticks(3);
        v4           = audio_in;
        sample_ready = 1'b1;
        do_tick();
        sample_ready = 1'b0;
        check("pp_no_ovf", {31'd0, overflow}, 32'd0);
        check("pp_head", {16'd0, sample_data}, {16'd0, exp_q[1]});
        exp_q[0] = exp_q[1];
        exp_q[1] = exp_q[2];
        exp_q[2] = exp_q[3];
        exp_q[3] = v4;
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", {31'd0, sample_valid}, 32'd1);
            check("drain_data", {16'd0, sample_data}, {16'd0, exp_q[k]});
            sample_ready = 1'b1;
            step();
            sample_ready = 1'b0;
        end
        check("drain_empty", {31'd0, sample_valid}, 32'd0);

        // 5: disable mid-run with two samples queued, then restart
        ticks(8);
        check("q2_valid", {31'd0, sample_valid}, 32'd1);
        enable = 1'b0;
        step();
        check("dis_state", {30'd0, state}, 32'd0);
        check("dis_valid", {31'd0, sample_valid}, 32'd0);
        check("dis_mic_run", {31'd0, mic_run}, 32'd0);
        ticks(1);
        check("dis_tick_ignored", {30'd0, state}, 32'd0);
        enable = 1'b1;
        step();
        check("reen_state", {30'd0, state}, 32'd1);
        check("reen_mic_run", {31'd0, mic_run}, 32'd1);
        ticks(1);
        check("reen_warmup", {30'd0, state}, 32'd1);

`ifdef PDM_MIC_PEAK_HOLD_EN
        // 6: peak hold with most-negative sample and clear
        ramp         = 1'b0;
        sample_ready = 1'b1;
        ticks(11);
        check("pk_run", {30'd0, state}, 32'd3);
        audio_in = 16'h8000;
        ticks(4);
        check("pk_neg", {17'd0, peak_level}, 32'd32767);
        audio_in = 16'd100;
        ticks(4);
        check("pk_hold", {17'd0, peak_level}, 32'd32767);
        peak_clr = 1'b1;
        step();
        peak_clr = 1'b0;
        check("pk_clr", {17'd0, peak_level}, 32'd0);
        ticks(4);
        check("pk_100", {17'd0, peak_level}, 32'd100);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
